// File: rtl/tx_mac_issue_unit.sv
// Transmit-side MAC issue engine: accepts one command, issues the MAC instruction,
// streams exactly N IFM and N WFM beats through registered output stages, then waits for MAC done.
module tx_mac_issue_unit #(
    parameter int W_ELEMENT = 8,
    parameter int W_CNT     = 16
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    output logic                      o_cmd_ready,
    input  logic                      i_cmd_valid,
    input  logic [1:0]                i_cmd_ifm_datatype,
    input  logic [1:0]                i_cmd_wfm_datatype,
    input  logic [W_CNT-1:0]          i_cmd_num_beats,
    output logic                      o_cmd_done,
    output logic                      o_ifm_src_ready,
    input  logic                      i_ifm_src_valid,
    input  logic [64*W_ELEMENT-1:0]   i_ifm_src_data,
    output logic                      o_wfm_src_ready,
    input  logic                      i_wfm_src_valid,
    input  logic [64*W_ELEMENT-1:0]   i_wfm_src_data,
    output logic                      o_mac_instruction_valid,
    input  logic                      i_mac_instruction_ready,
    output logic [4+W_CNT-1:0]        o_mac_instruction,
    output logic                      o_mac_ifm_valid,
    input  logic                      i_mac_ifm_ready,
    output logic [64*W_ELEMENT-1:0]   o_mac_ifm,
    output logic                      o_mac_wfm_valid,
    input  logic                      i_mac_wfm_ready,
    output logic [64*W_ELEMENT-1:0]   o_mac_wfm,
    input  logic                      i_mac_done,
    output logic                      o_mac_done_ready
);

    localparam int W_DATA = 64 * W_ELEMENT;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_STREAM    = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    state_t              r_state;
    logic [W_CNT-1:0]    r_num;
    logic [W_CNT-1:0]    r_ifm_cnt;
    logic [W_CNT-1:0]    r_wfm_cnt;
    logic                r_instr_valid;
    logic [4+W_CNT-1:0]  r_instr;
    logic                r_ifm_valid;
    logic                r_wfm_valid;
    logic [W_DATA-1:0]   r_ifm_data;
    logic [W_DATA-1:0]   r_wfm_data;
    logic                r_cmd_done;
    logic                r_done_ready;

    logic w_in_stream;
    logic w_ifm_src_ready;
    logic w_wfm_src_ready;
    logic w_ifm_load;
    logic w_wfm_load;
    logic w_stream_end;

    // Each lane pulls a new beat only while beats remain and its output stage is free or draining
    assign w_in_stream     = (r_state == ST_STREAM);
    assign w_ifm_src_ready = w_in_stream && (r_ifm_cnt < r_num) && (!r_ifm_valid || i_mac_ifm_ready);
    assign w_wfm_src_ready = w_in_stream && (r_wfm_cnt < r_num) && (!r_wfm_valid || i_mac_wfm_ready);
    assign w_ifm_load      = w_ifm_src_ready && i_ifm_src_valid;
    assign w_wfm_load      = w_wfm_src_ready && i_wfm_src_valid;
    assign w_stream_end    = (r_ifm_cnt == r_num) && (r_wfm_cnt == r_num) && !r_ifm_valid && !r_wfm_valid;

    // Command sequencing FSM plus the two independent data lanes
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_num         <= {W_CNT{1'b0}};
            r_ifm_cnt     <= {W_CNT{1'b0}};
            r_wfm_cnt     <= {W_CNT{1'b0}};
            r_instr_valid <= 1'b0;
            r_instr       <= {(4+W_CNT){1'b0}};
            r_ifm_valid   <= 1'b0;
            r_wfm_valid   <= 1'b0;
            r_ifm_data    <= {W_DATA{1'b0}};
            r_wfm_data    <= {W_DATA{1'b0}};
            r_cmd_done    <= 1'b0;
            r_done_ready  <= 1'b0;
        end else begin
            r_cmd_done <= 1'b0;

            if (w_ifm_load) begin
                r_ifm_data  <= i_ifm_src_data;
                r_ifm_valid <= 1'b1;
                r_ifm_cnt   <= r_ifm_cnt + {{(W_CNT-1){1'b0}}, 1'b1};
            end else if (r_ifm_valid && i_mac_ifm_ready) begin
                r_ifm_valid <= 1'b0;
            end

            if (w_wfm_load) begin
                r_wfm_data  <= i_wfm_src_data;
                r_wfm_valid <= 1'b1;
                r_wfm_cnt   <= r_wfm_cnt + {{(W_CNT-1){1'b0}}, 1'b1};
            end else if (r_wfm_valid && i_mac_wfm_ready) begin
                r_wfm_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (i_cmd_valid) begin
                        r_instr       <= {i_cmd_ifm_datatype, i_cmd_wfm_datatype, i_cmd_num_beats};
                        r_num         <= i_cmd_num_beats;
                        r_ifm_cnt     <= {W_CNT{1'b0}};
                        r_wfm_cnt     <= {W_CNT{1'b0}};
                        r_instr_valid <= 1'b1;
                        r_state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (i_mac_instruction_ready) begin
                        r_instr_valid <= 1'b0;
                        if (r_num == {W_CNT{1'b0}}) begin
                            r_done_ready <= 1'b1;
                            r_state      <= ST_WAIT_DONE;
                        end else begin
                            r_state <= ST_STREAM;
                        end
                    end
                end
                ST_STREAM: begin
                    if (w_stream_end) begin
                        r_done_ready <= 1'b1;
                        r_state      <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (i_mac_done) begin
                        r_done_ready <= 1'b0;
                        r_cmd_done   <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_cmd_ready             = (r_state == ST_IDLE);
    assign o_cmd_done              = r_cmd_done;
    assign o_ifm_src_ready         = w_ifm_src_ready;
    assign o_wfm_src_ready         = w_wfm_src_ready;
    assign o_mac_instruction_valid = r_instr_valid;
    assign o_mac_instruction       = r_instr;
    assign o_mac_ifm_valid         = r_ifm_valid;
    assign o_mac_ifm               = r_ifm_data;
    assign o_mac_wfm_valid         = r_wfm_valid;
    assign o_mac_wfm               = r_wfm_data;
    assign o_mac_done_ready        = r_done_ready;

endmodule

// File: tb/tb_tx_mac_issue_unit.sv
// Scoreboard bench for tx_mac_issue_unit: stimulus pushes expected instructions/beats,
// a negedge monitor pops and compares whenever the DUT presents a transfer.
module tb_tx_mac_issue_unit;

    localparam int W_ELEMENT = 8;
    localparam int W_CNT     = 16;
    localparam int W_DATA    = 64 * W_ELEMENT;
    localparam logic [1:0] DT_FP16 = 2'b00;
    localparam logic [1:0] DT_FP8  = 2'b01;
    localparam logic [1:0] DT_INT9 = 2'b10;
    localparam logic [W_DATA-1:0] JUNK = {16{32'hDEAD_BEEF}};

    logic                 clk = 1'b0;
    logic                 i_reset = 1'b1;
    logic                 o_cmd_ready;
    logic                 i_cmd_valid = 1'b0;
    logic [1:0]           i_cmd_ifm_datatype = 2'b00;
    logic [1:0]           i_cmd_wfm_datatype = 2'b00;
    logic [W_CNT-1:0]     i_cmd_num_beats = '0;
    logic                 o_cmd_done;
    logic                 o_ifm_src_ready;
    logic                 i_ifm_src_valid = 1'b0;
    logic [W_DATA-1:0]    i_ifm_src_data = '0;
    logic                 o_wfm_src_ready;
    logic                 i_wfm_src_valid = 1'b0;
    logic [W_DATA-1:0]    i_wfm_src_data = '0;
    logic                 o_mac_instruction_valid;
    logic                 i_mac_instruction_ready = 1'b1;
    logic [4+W_CNT-1:0]   o_mac_instruction;
    logic                 o_mac_ifm_valid;
    logic                 i_mac_ifm_ready = 1'b1;
    logic [W_DATA-1:0]    o_mac_ifm;
    logic                 o_mac_wfm_valid;
    logic                 i_mac_wfm_ready = 1'b1;
    logic [W_DATA-1:0]    o_mac_wfm;
    logic                 i_mac_done = 1'b0;
    logic                 o_mac_done_ready;

    tx_mac_issue_unit #(.W_ELEMENT(W_ELEMENT), .W_CNT(W_CNT)) dut (
        .i_clk(clk), .i_reset(i_reset),
        .o_cmd_ready(o_cmd_ready), .i_cmd_valid(i_cmd_valid),
        .i_cmd_ifm_datatype(i_cmd_ifm_datatype), .i_cmd_wfm_datatype(i_cmd_wfm_datatype),
        .i_cmd_num_beats(i_cmd_num_beats), .o_cmd_done(o_cmd_done),
        .o_ifm_src_ready(o_ifm_src_ready), .i_ifm_src_valid(i_ifm_src_valid), .i_ifm_src_data(i_ifm_src_data),
        .o_wfm_src_ready(o_wfm_src_ready), .i_wfm_src_valid(i_wfm_src_valid), .i_wfm_src_data(i_wfm_src_data),
        .o_mac_instruction_valid(o_mac_instruction_valid), .i_mac_instruction_ready(i_mac_instruction_ready),
        .o_mac_instruction(o_mac_instruction),
        .o_mac_ifm_valid(o_mac_ifm_valid), .i_mac_ifm_ready(i_mac_ifm_ready), .o_mac_ifm(o_mac_ifm),
        .o_mac_wfm_valid(o_mac_wfm_valid), .i_mac_wfm_ready(i_mac_wfm_ready), .o_mac_wfm(o_mac_wfm),
        .i_mac_done(i_mac_done), .o_mac_done_ready(o_mac_done_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    logic [W_DATA-1:0]  ifm_src_q[$];
    logic [W_DATA-1:0]  wfm_src_q[$];
    logic [W_DATA-1:0]  exp_ifm_q[$];
    logic [W_DATA-1:0]  exp_wfm_q[$];
    logic [4+W_CNT-1:0] exp_instr_q[$];
    int expected_done = 0;

    bit ifm_src_en = 1'b1;
    bit wfm_src_en = 1'b1;
    bit ifm_rdy_mode = 1'b0;
    int rdy_phase = 0;
    bit ifm_src_fire = 1'b0;
    bit wfm_src_fire = 1'b0;
    int ifm_pops = 0, wfm_pops = 0;
    int ifm_xfers = 0, wfm_xfers = 0;
    int ifm_first_cyc = 0, ifm_last_cyc = 0, wfm_first_cyc = 0, wfm_last_cyc = 0;
    bit ifm_stall_prev = 1'b0, wfm_stall_prev = 1'b0, rst_prev = 1'b0;
    logic [W_DATA-1:0] ifm_prev_data = '0, wfm_prev_data = '0;

    task automatic check(input string nm, input logic [W_DATA-1:0] act, input logic [W_DATA-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Source models and MAC-side ready pattern, updated just after each rising edge
    always @(posedge clk) begin
        #1;
        cycle++;
        if (ifm_src_fire && ifm_src_q.size() > 0) void'(ifm_src_q.pop_front());
        if (wfm_src_fire && wfm_src_q.size() > 0) void'(wfm_src_q.pop_front());
        i_ifm_src_valid = ifm_src_en;
        i_ifm_src_data  = (ifm_src_q.size() > 0) ? ifm_src_q[0] : JUNK;
        i_wfm_src_valid = wfm_src_en;
        i_wfm_src_data  = (wfm_src_q.size() > 0) ? wfm_src_q[0] : JUNK;
        i_mac_ifm_ready = ifm_rdy_mode ? (rdy_phase == 0) : 1'b1;
        rdy_phase = (rdy_phase == 2) ? 0 : rdy_phase + 1;
    end

    // Monitor: compares every transfer the DUT presents against the scoreboard
    always @(negedge clk) begin
        ifm_src_fire = o_ifm_src_ready && i_ifm_src_valid;
        wfm_src_fire = o_wfm_src_ready && i_wfm_src_valid;
        if (ifm_src_fire) ifm_pops++;
        if (wfm_src_fire) wfm_pops++;
        if (o_mac_instruction_valid && i_mac_instruction_ready) begin
            if (exp_instr_q.size() == 0) check("instr_unexpected", 1, 0);
            else check("instr", W_DATA'(o_mac_instruction), W_DATA'(exp_instr_q.pop_front()));
        end
        if (ifm_stall_prev && !rst_prev) begin
            check("ifm_valid_held", W_DATA'(o_mac_ifm_valid), 1);
            check("ifm_data_held", o_mac_ifm, ifm_prev_data);
        end
        if (wfm_stall_prev && !rst_prev) begin
            check("wfm_valid_held", W_DATA'(o_mac_wfm_valid), 1);
            check("wfm_data_held", o_mac_wfm, wfm_prev_data);
        end
        if (o_mac_ifm_valid && i_mac_ifm_ready && !i_reset) begin
            if (exp_ifm_q.size() == 0) check("ifm_unexpected", 1, 0);
            else check("ifm_beat", o_mac_ifm, exp_ifm_q.pop_front());
            if (ifm_xfers == 0) ifm_first_cyc = cycle;
            ifm_last_cyc = cycle;
            ifm_xfers++;
        end
        if (o_mac_wfm_valid && i_mac_wfm_ready && !i_reset) begin
            if (exp_wfm_q.size() == 0) check("wfm_unexpected", 1, 0);
            else check("wfm_beat", o_mac_wfm, exp_wfm_q.pop_front());
            if (wfm_xfers == 0) wfm_first_cyc = cycle;
            wfm_last_cyc = cycle;
            wfm_xfers++;
        end
        if (o_mac_done_ready) check("done_ready_beats_left", exp_ifm_q.size() + exp_wfm_q.size(), 0);
        if (o_cmd_done) begin
            check("cmd_done_expected", W_DATA'(expected_done > 0), 1);
            check("cmd_ready_with_done", W_DATA'(o_cmd_ready), 1);
            if (expected_done > 0) expected_done--;
        end
        ifm_stall_prev = o_mac_ifm_valid && !i_mac_ifm_ready;
        wfm_stall_prev = o_mac_wfm_valid && !i_mac_wfm_ready;
        ifm_prev_data  = o_mac_ifm;
        wfm_prev_data  = o_mac_wfm;
        rst_prev       = i_reset;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue_cmd(input logic [1:0] dti, input logic [1:0] dtw, input int n, input int id);
        logic [W_DATA-1:0] d;
        int k;
        ifm_pops = 0; wfm_pops = 0; ifm_xfers = 0; wfm_xfers = 0;
        for (int b = 0; b < n; b++) begin
            d = {16{id[15:0], b[15:0]}};
            ifm_src_q.push_back(d);  exp_ifm_q.push_back(d);
            wfm_src_q.push_back(~d); exp_wfm_q.push_back(~d);
        end
        exp_instr_q.push_back({dti, dtw, n[W_CNT-1:0]});
        i_cmd_ifm_datatype = dti;
        i_cmd_wfm_datatype = dtw;
        i_cmd_num_beats    = n[W_CNT-1:0];
        i_cmd_valid        = 1'b1;
        k = 0;
        @(negedge clk);
        while (!o_cmd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("cmd_accept_timeout", W_DATA'(k < 50), 1);
        tick();
        i_cmd_valid = 1'b0;
        @(negedge clk);
        check("instr_latency", W_DATA'(o_mac_instruction_valid), 1);
        tick();
    endtask

    task automatic wait_done_ready();
        int k;
        k = 0;
        @(negedge clk);
        while (!o_mac_done_ready && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("done_ready_timeout", W_DATA'(k < 300), 1);
    endtask

    task automatic finish_cmd(input int n, input int done_delay);
        wait_done_ready();
        tick();
        repeat (done_delay - 1) tick();
        i_mac_done = 1'b1;
        expected_done++;
        tick();
        i_mac_done = 1'b0;
        @(negedge clk);
        check("cmd_done_pulse", W_DATA'(o_cmd_done), 1);
        tick();
        check("ifm_src_pops", ifm_pops, n);
        check("wfm_src_pops", wfm_pops, n);
        check("ifm_beats_left", exp_ifm_q.size(), 0);
        check("wfm_beats_left", exp_wfm_q.size(), 0);
    endtask

    initial begin
        int k;
        repeat (3) tick();
        i_reset = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready", W_DATA'(o_cmd_ready), 1);
        check("rst_instr_valid", W_DATA'(o_mac_instruction_valid), 0);
        check("rst_ifm_valid", W_DATA'(o_mac_ifm_valid), 0);
        check("rst_wfm_valid", W_DATA'(o_mac_wfm_valid), 0);
        check("rst_cmd_done", W_DATA'(o_cmd_done), 0);
        check("rst_done_ready", W_DATA'(o_mac_done_ready), 0);
        check("rst_instr", W_DATA'(o_mac_instruction), 0);
        tick();

        // Basic run with continuous flow
        issue_cmd(DT_FP16, DT_FP16, 4, 1);
        finish_cmd(4, 3);
        check("ifm_back_to_back", ifm_last_cyc - ifm_first_cyc, 3);
        check("wfm_back_to_back", wfm_last_cyc - wfm_first_cyc, 3);

        // IFM backpressure, WFM free-running
        ifm_rdy_mode = 1'b1;
        issue_cmd(DT_FP8, DT_INT9, 3, 2);
        finish_cmd(3, 1);
        ifm_rdy_mode = 1'b0;
        tick();

        // WFM source bubble mid-stream
        issue_cmd(DT_INT9, DT_FP16, 8, 3);
        k = 0;
        while (wfm_xfers < 2 && k < 100) begin
            tick();
            k++;
        end
        wfm_src_en = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        check("bubble_wfm_valid_low", W_DATA'(o_mac_wfm_valid), 0);
        tick();
        wfm_src_en = 1'b1;
        finish_cmd(8, 2);

        // Zero-beat command
        issue_cmd(DT_FP8, DT_FP8, 0, 4);
        finish_cmd(0, 1);

        // Done held early from the issue phase
        issue_cmd(DT_FP16, DT_FP8, 4, 5);
        i_mac_done = 1'b1;
        expected_done++;
        wait_done_ready();
        @(negedge clk);
        check("early_done_first_cycle", W_DATA'(o_cmd_done), 1);
        tick();
        i_mac_done = 1'b0;
        check("early_ifm_pops", ifm_pops, 4);
        check("early_wfm_pops", wfm_pops, 4);
        tick();

        // Reset in the middle of an 8-beat stream
        issue_cmd(DT_FP16, DT_FP16, 8, 6);
        k = 0;
        while (ifm_xfers < 2 && k < 100) begin
            tick();
            k++;
        end
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        ifm_src_q.delete(); wfm_src_q.delete();
        exp_ifm_q.delete(); exp_wfm_q.delete();
        @(negedge clk);
        check("midrst_ifm_valid", W_DATA'(o_mac_ifm_valid), 0);
        check("midrst_wfm_valid", W_DATA'(o_mac_wfm_valid), 0);
        check("midrst_instr_valid", W_DATA'(o_mac_instruction_valid), 0);
        check("midrst_cmd_ready", W_DATA'(o_cmd_ready), 1);
        check("midrst_cmd_done", W_DATA'(o_cmd_done), 0);
        tick();
        issue_cmd(DT_INT9, DT_INT9, 2, 7);
        finish_cmd(2, 2);

        repeat (3) tick();
        check("final_instr_left", exp_instr_q.size(), 0);
        check("final_done_left", expected_done, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
